rx_frame_counter: RTL
=====================

Name: rx_frame_counter

Overview:
- Parametrised successor of the fixed 16-character UART counter used in the timing-attack path.
- Consumes the byte stream from the UART receiver (data + 1-cycle valid strobe).
- Groups bytes into frames, terminated by character count, optional terminator byte, or idle timeout.
- Reports frame length and first-to-last-byte cycle duration, which the timing-attack controller uses to measure target response time.

Parameters:
DATA_W, 8, width of received character
MAX_CHARS, 16, character count that completes a frame (1..2^CNT_W-1)
CNT_W, 5, width of character counter and frame_len
TS_W, 32, width of cycle-duration counter
TIMEOUT_CYC, 100000, idle cycles after last byte that close a partial frame (0 disables)
TERM_EN, 1, 1 = TERM_CHAR closes a frame
TERM_CHAR, 8'h0A, terminator character
AUTO_RESTART, 0, 0 = hold DONE until clr; 1 = return to IDLE on next cycle

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
clr  in  1  acknowledge/clear result; returns DONE to IDLE
rx_data  in  DATA_W  received character, valid only with rx_valid
rx_valid  in  1  1-cycle strobe per received character
busy  out  1  high in COLLECT
frame_done  out  1  1-cycle pulse when a frame closes
frame_valid  out  1  level: result registers hold a closed frame
frame_len  out  CNT_W  characters in the closed frame, terminator included
frame_cycles  out  TS_W  cycles from first-byte strobe to closing event, saturating
end_cause  out  2  00 count, 01 terminator, 10 timeout, 11 reserved
overflow  out  1  1-cycle pulse: rx_valid arrived in DONE and the byte was dropped

Behaviour:
- Reset: state IDLE. All outputs 0: busy, frame_done, frame_valid, frame_len, frame_cycles, end_cause, overflow. Internal counters 0.
- States: IDLE, COLLECT, DONE.
- IDLE:
  - On rx_valid: char_cnt <= 1, dur <= 0, idle <= 0; go to COLLECT.
  - If that first byte already closes the frame (MAX_CHARS==1, or TERM_EN with rx_data==TERM_CHAR), go directly to close.
  - A byte arriving in IDLE clears frame_valid.
- COLLECT:
  - dur increments every cycle, saturating at all-ones.
  - idle increments on cycles without rx_valid and is cleared on rx_valid.
  - On rx_valid: char_cnt++.
- Close priority on the same cycle: count (char_cnt+1==MAX_CHARS) > terminator > timeout.
  - Timeout fires when idle reaches TIMEOUT_CYC-1 with no rx_valid that cycle.
  - An rx_valid on the timeout cycle cancels the timeout.
- Close action, registered:
  - frame_len <= count including the closing byte. On timeout, frame_len <= bytes received.
  - frame_cycles <= dur at close (dur+1 when closing on a byte strobe).
  - Set end_cause. frame_valid <= 1. frame_done pulses the next cycle.
  - Go to DONE, or to IDLE if AUTO_RESTART=1.
- DONE (AUTO_RESTART=0):
  - Outputs held.
  - rx_valid is dropped and pulses overflow.
  - clr -> IDLE next cycle; frame_valid stays set until a new first byte.
  - clr and rx_valid on the same cycle: clr wins, the byte is dropped, overflow pulses.
- AUTO_RESTART=1:
  - A byte in the cycle after a close starts a new frame normally.
  - overflow never pulses.
- clr in COLLECT aborts the frame: go to IDLE, no frame_done, result registers unchanged.
- rst mid-frame: immediate return to reset values; the partial frame is discarded.
- Latency: frame_done is asserted 1 cycle after the closing rx_valid or timeout cycle.
- Widths: char_cnt never exceeds MAX_CHARS. Parameter check: MAX_CHARS < 2^CNT_W, elaborated with an error otherwise.

Test Plan:
- 16 bytes 0x41, 10-cycle spacing, TERM_EN=0 -> frame_done once after 16th strobe; frame_len=16, end_cause=00, frame_cycles=151.
- Bytes "ab\n" (TERM_EN=1), 4-cycle spacing -> frame_len=3, end_cause=01, frame_cycles=9, busy low after close.
- 5 bytes then silence, TIMEOUT_CYC=50 -> frame_done 50 cycles after 5th byte; frame_len=5, end_cause=10; byte on cycle 49 instead extends the frame.
- AUTO_RESTART=0, closed frame, 2 extra bytes -> 2 overflow pulses, results unchanged; clr -> IDLE; next byte starts a new frame, frame_valid drops.
- rst asserted after byte 7 of 16 -> all outputs 0 next cycle; following 16 bytes produce frame_len=16 normally.
- MAX_CHARS=4 with 4th byte == TERM_CHAR -> end_cause=00 (count priority), frame_len=4.

Source files
------------

// File: rtl/rx_frame_counter_if.sv
// rx_frame_counter_if: byte-stream input and frame-result bundle for rx_frame_counter
interface rx_frame_counter_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 5,
    parameter int TS_W   = 32
);
    logic              i_clr;
    logic [DATA_W-1:0] i_rx_data;
    logic              i_rx_valid;
    logic              o_busy;
    logic              o_frame_done;
    logic              o_frame_valid;
    logic [CNT_W-1:0]  o_frame_len;
    logic [TS_W-1:0]   o_frame_cycles;
    logic [1:0]        o_end_cause;
    logic              o_overflow;

    modport master (
        output i_clr, i_rx_data, i_rx_valid,
        input  o_busy, o_frame_done, o_frame_valid, o_frame_len, o_frame_cycles, o_end_cause, o_overflow
    );

    modport slave (
        input  i_clr, i_rx_data, i_rx_valid,
        output o_busy, o_frame_done, o_frame_valid, o_frame_len, o_frame_cycles, o_end_cause, o_overflow
    );
endinterface

// File: rtl/rx_frame_counter.sv
// rx_frame_counter: groups received bytes into frames closed by count, terminator or idle timeout
module rx_frame_counter #(
    parameter int                DATA_W       = 8,
    parameter int                MAX_CHARS    = 16,
    parameter int                CNT_W        = 5,
    parameter int                TS_W         = 32,
    parameter int                TIMEOUT_CYC  = 100000,
    parameter bit                TERM_EN      = 1'b1,
    parameter logic [DATA_W-1:0] TERM_CHAR    = DATA_W'(8'h0A),
    parameter bit                AUTO_RESTART = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    rx_frame_counter_if.slave bus
);
    if (MAX_CHARS < 1 || MAX_CHARS >= (1 << CNT_W)) begin : g_param_err
        $error("rx_frame_counter: MAX_CHARS must lie in 1..2**CNT_W-1");
    end

    localparam int                IDLE_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [IDLE_W-1:0] TO_LIM  = IDLE_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_CHARS);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_t;

    state_t              r_state, w_state;
    logic [CNT_W-1:0]    r_cnt, w_cnt, w_cnt_inc;
    logic [TS_W-1:0]     r_dur, w_dur, w_dur_inc, w_dur_inc2;
    logic [IDLE_W-1:0]   r_idle, w_idle, w_idle_inc;
    logic [CNT_W-1:0]    r_len, w_len;
    logic [TS_W-1:0]     r_cyc, w_cyc;
    logic [1:0]          r_cause, w_cause;
    logic                r_valid, w_valid;
    logic                r_done, r_ovf;
    logic                w_close, w_term, w_timeout, w_ovf;

    // Incremented counters; duration saturates so a stalled target cannot wrap the measurement
    assign w_cnt_inc  = r_cnt + 1'b1;
    assign w_dur_inc  = (&r_dur) ? r_dur : r_dur + 1'b1;
    assign w_dur_inc2 = (&w_dur_inc) ? w_dur_inc : w_dur_inc + 1'b1;
    assign w_idle_inc = r_idle + 1'b1;
    assign w_term     = TERM_EN && bus.i_rx_data == TERM_CHAR;
    assign w_timeout  = (TIMEOUT_CYC != 0) && !bus.i_rx_valid && w_idle_inc >= TO_LIM;
    assign w_ovf      = r_state == S_DONE && bus.i_rx_valid;

    // Next state and frame accounting; a close overrides the state chosen by the case arms
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_dur   = r_dur;
        w_idle  = r_idle;
        w_len   = r_len;
        w_cyc   = r_cyc;
        w_cause = r_cause;
        w_valid = r_valid;
        w_close = 1'b0;
        case (r_state)
            S_IDLE: if (bus.i_rx_valid) begin
                w_state = S_COLLECT;
                w_cnt   = CNT_W'(1);
                w_dur   = '0;
                w_idle  = '0;
                w_valid = 1'b0;
                if (MAX_CHARS == 1 || w_term) begin
                    w_close = 1'b1;
                    w_len   = CNT_W'(1);
                    w_cyc   = TS_W'(1);
                    w_cause = (MAX_CHARS == 1) ? 2'b00 : 2'b01;
                end
            end
            S_COLLECT: if (bus.i_clr) begin
                w_state = S_IDLE;
            end else begin
                w_dur  = w_dur_inc;
                w_idle = bus.i_rx_valid ? '0 : w_idle_inc;
                w_cnt  = bus.i_rx_valid ? w_cnt_inc : r_cnt;
                if (bus.i_rx_valid && (w_cnt_inc == MAX_CNT || w_term)) begin
                    w_close = 1'b1;
                    w_len   = w_cnt_inc;
                    w_cyc   = w_dur_inc2;
                    w_cause = (w_cnt_inc == MAX_CNT) ? 2'b00 : 2'b01;
                end else if (w_timeout) begin
                    w_close = 1'b1;
                    w_len   = r_cnt;
                    w_cyc   = w_dur_inc;
                    w_cause = 2'b10;
                end
            end
            S_DONE: w_state = bus.i_clr ? S_IDLE : S_DONE;
            default: w_state = S_IDLE;
        endcase
        if (w_close) begin
            w_valid = 1'b1;
            w_state = AUTO_RESTART ? S_IDLE : S_DONE;
        end
    end

    // State, counters and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_dur   <= '0;
            r_idle  <= '0;
            r_len   <= '0;
            r_cyc   <= '0;
            r_cause <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_dur   <= w_dur;
            r_idle  <= w_idle;
            r_len   <= w_len;
            r_cyc   <= w_cyc;
            r_cause <= w_cause;
            r_valid <= w_valid;
            r_done  <= w_close;
            r_ovf   <= w_ovf;
        end
    end

    assign bus.o_busy         = r_state == S_COLLECT;
    assign bus.o_frame_done   = r_done;
    assign bus.o_frame_valid  = r_valid;
    assign bus.o_frame_len    = r_len;
    assign bus.o_frame_cycles = r_cyc;
    assign bus.o_end_cause    = r_cause;
    assign bus.o_overflow     = r_ovf;
endmodule
